// File: rtl/int32_alu_responder.sv
// int32 ALU responder: two-stage compute pipeline feeding a credit-protected result FIFO.
// Latency 2 edges accept->head; int32_ir drops once in-flight + buffered ops reach DEPTH.

module int32_alu_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] head_dat_o,
   output logic         vld_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [CW-1:0] occ_q;
   logic          pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign vld_o      = (occ_q != '0);
   assign pop_ok     = pop_i && vld_o;
   assign head_dat_o = vld_o ? mem_q[rd_q] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push_i) wr_q <= nxt(wr_q);
         if (pop_ok) rd_q <= nxt(rd_q);
         occ_q <= occ_q + CW'(push_i) - CW'(pop_ok);
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= push_dat_i;
   end
endmodule

module int32_alu_responder #(
   parameter int DATA_W = 32,
   parameter int OPC_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [OPC_W-1:0]  int32_opc,
   input  logic [DATA_W-1:0] int32_a,
   input  logic [DATA_W-1:0] int32_b,
   input  logic              int32_iv,
   output logic              int32_ir,
   output logic [DATA_W-1:0] int32_y,
   output logic              int32_err,
   output logic              int32_ov,
   input  logic              int32_or,
   output logic              int32_busy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(DATA_W);

   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_SRL = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_SRA = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_MIN = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_MAX = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_SLT = OPC_W'(11);

   logic              ir_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic              s1_vld_q;
   logic [OPC_W-1:0]  s1_opc_q;
   logic [DATA_W-1:0] s1_a_q;
   logic [DATA_W-1:0] s1_b_q;
   logic              s2_vld_q;
   logic [DATA_W-1:0] s2_y_q;
   logic              s2_err_q;
   logic [DATA_W-1:0] alu_y;
   logic              alu_err;
   logic              lt;
   logic [SW-1:0]     shamt;
   logic              accept;
   logic              pop;
   logic [DATA_W:0]   head_dat;

   assign accept = int32_iv && ir_q;
   assign pop    = int32_ov && int32_or;
   assign shamt  = s1_b_q[SW-1:0];

   always_comb begin
      alu_y   = '0;
      alu_err = 1'b0;
      lt      = $signed(s1_a_q) < $signed(s1_b_q);
      case (s1_opc_q)
         OP_ADD:  alu_y = s1_a_q + s1_b_q;
         OP_SUB:  alu_y = s1_a_q - s1_b_q;
         OP_MUL:  alu_y = s1_a_q * s1_b_q;
         OP_AND:  alu_y = s1_a_q & s1_b_q;
         OP_OR:   alu_y = s1_a_q | s1_b_q;
         OP_XOR:  alu_y = s1_a_q ^ s1_b_q;
         OP_SHL:  alu_y = s1_a_q << shamt;
         OP_SRL:  alu_y = s1_a_q >> shamt;
         OP_SRA:  alu_y = $unsigned($signed(s1_a_q) >>> shamt);
         OP_MIN:  alu_y = lt ? s1_a_q : s1_b_q;
         OP_MAX:  alu_y = lt ? s1_b_q : s1_a_q;
         OP_SLT:  alu_y = DATA_W'(lt);
         default: alu_err = 1'b1;
      endcase
   end

   // Credits cover both pipeline stages and the FIFO, so stage 2 can always push.
   always_comb begin
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q     <= 1'b0;
         cnt_q    <= '0;
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
      end else begin
         ir_q     <= (cnt_d < CW'(DEPTH));
         cnt_q    <= cnt_d;
         s1_vld_q <= accept;
         s2_vld_q <= s1_vld_q;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         s1_opc_q <= int32_opc;
         s1_a_q   <= int32_a;
         s1_b_q   <= int32_b;
      end
      s2_y_q   <= alu_y;
      s2_err_q <= alu_err;
   end

   int32_alu_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clock),
      .rst_i      (reset),
      .push_i     (s2_vld_q),
      .push_dat_i ({s2_err_q, s2_y_q}),
      .pop_i      (int32_or),
      .head_dat_o (head_dat),
      .vld_o      (int32_ov)
   );

   assign int32_ir   = ir_q;
   assign int32_busy = (cnt_q != '0);
   assign int32_y    = head_dat[DATA_W-1:0];
   assign int32_err  = head_dat[DATA_W];
endmodule

// File: tb/tb_int32_alu_responder.sv
// Directed bench for int32_alu_responder: hand-computed vectors, an output scoreboard
// fed in accept order, and an independent ALU model for the randomized credit phase.
module tb_int32_alu_responder;
   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  int32_opc;
   logic [31:0] int32_a;
   logic [31:0] int32_b;
   logic        int32_iv;
   logic        int32_ir;
   logic [31:0] int32_y;
   logic        int32_err;
   logic        int32_ov;
   logic        int32_or;
   logic        int32_busy;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;
   logic [32:0] exp_q [$];
   logic [32:0] mon_e;

   logic [3:0]  st_op [8];
   logic [31:0] st_a  [8];
   logic [31:0] st_b  [8];
   logic [31:0] st_y  [8];

   int32_alu_responder #(.DATA_W(32), .OPC_W(4), .DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .int32_opc  (int32_opc),
      .int32_a    (int32_a),
      .int32_b    (int32_b),
      .int32_iv   (int32_iv),
      .int32_ir   (int32_ir),
      .int32_y    (int32_y),
      .int32_err  (int32_err),
      .int32_ov   (int32_ov),
      .int32_or   (int32_or),
      .int32_busy (int32_busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int32_opc = op;
      int32_a   = x;
      int32_b   = y;
      int32_iv  = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         step();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      step();
   endtask

   // Independent reference: signed compare via sign bits, SRA via explicit sign fill.
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [4:0]  sh;
      logic        slt;
      logic [31:0] r;
      sh  = b[4:0];
      slt = (a[31] != b[31]) ? a[31] : (a < b);
      r   = 32'd0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a + ~b + 32'd1;
         4'd2:  r = a * b;
         4'd3:  r = a & b;
         4'd4:  r = a | b;
         4'd5:  r = a ^ b;
         4'd6:  r = a << sh;
         4'd7:  r = a >> sh;
         4'd8:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd9:  r = slt ? a : b;
         4'd10: r = slt ? b : a;
         4'd11: r = {31'd0, slt};
         default: return {1'b1, 32'd0};
      endcase
      return {1'b0, r};
   endfunction

   // Scoreboard: a pop happens at the next rising edge whenever ov && or at the falling edge.
   always @(negedge clock) begin
      if (!reset && int32_ov && int32_or) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_y", int32_y, mon_e[31:0]);
            chk("pop_err", 32'(int32_err), 32'(mon_e[32]));
         end
         pops++;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int accepts;
      int n;
      int pops0;
      logic took;
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      st_op = '{4'd1, 4'd2, 4'd8, 4'd6, 4'd9, 4'd10, 4'd11, 4'd5};
      st_a  = '{32'd5, 32'h0000FFFF, 32'h80000000, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFD,
                32'hFFFFFFFF, 32'hF0F0F0F0};
      st_b  = '{32'd7, 32'h00010001, 32'd4, 32'd35, 32'd2, 32'd2, 32'd2, 32'h0FF00FF0};
      st_y  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hF8000000, 32'h00000008, 32'hFFFFFFFD,
                32'h00000002, 32'h00000001, 32'hFF00FF00};

      reset = 1'b1; int32_iv = 1'b0; int32_or = 1'b0;
      int32_opc = 4'd0; int32_a = 32'd0; int32_b = 32'd0;
      repeat (3) step();
      chk("rst_ir", 32'(int32_ir), 32'd0);
      chk("rst_ov", 32'(int32_ov), 32'd0);
      chk("rst_y", int32_y, 32'd0);
      chk("rst_err", 32'(int32_err), 32'd0);
      chk("rst_busy", 32'(int32_busy), 32'd0);
      reset = 1'b0;
      step();
      chk("ir_after_reset", 32'(int32_ir), 32'd1);

      // Single ADD: overflow wraps, result at head two edges after accept.
      int32_or = 1'b1;
      drive(4'd0, 32'h7FFFFFFF, 32'd1);
      exp_q.push_back({1'b0, 32'h80000000});
      step();
      int32_iv = 1'b0;
      chk("add_ov_k", 32'(int32_ov), 32'd0);
      chk("add_busy", 32'(int32_busy), 32'd1);
      step();
      chk("add_ov_k1", 32'(int32_ov), 32'd0);
      step();
      chk("add_ov_k2", 32'(int32_ov), 32'd1);
      chk("add_y", int32_y, 32'h80000000);
      chk("add_err", 32'(int32_err), 32'd0);
      step();
      chk("add_ov_after_pop", 32'(int32_ov), 32'd0);
      chk("add_busy_after_pop", 32'(int32_busy), 32'd0);

      // Back-to-back stream, one result per cycle.
      for (int i = 0; i < 8; i++) begin
         drive(st_op[i], st_a[i], st_b[i]);
         exp_q.push_back({1'b0, st_y[i]});
         chk("stream_ir", 32'(int32_ir), 32'd1);
         step();
         chk("stream_ov", 32'(int32_ov), 32'(i >= 2));
      end
      int32_iv = 1'b0;
      step();
      chk("stream_tail_ov", 32'(int32_ov), 32'd1);
      step();
      chk("stream_tail_ov", 32'(int32_ov), 32'd1);
      step();
      chk("stream_done_ov", 32'(int32_ov), 32'd0);
      chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: iv held high, or low -> exactly DEPTH accepts.
      int32_or = 1'b0;
      accepts = 0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         drive(4'd0, 32'(100 + n), 32'(n));
         took = int32_ir;
         if (took) begin
            exp_q.push_back({1'b0, 32'(100 + 2 * n)});
            accepts++;
         end
         step();
         if (took) n++;
      end
      chk("bp_accepts", 32'(accepts), 32'd4);
      chk("bp_ir_low", 32'(int32_ir), 32'd0);
      chk("bp_ov", 32'(int32_ov), 32'd1);
      chk("bp_head", int32_y, 32'd100);
      step();
      chk("bp_head_hold", int32_y, 32'd100);
      chk("bp_busy", 32'(int32_busy), 32'd1);
      int32_iv = 1'b0;
      int32_or = 1'b1;
      step();
      chk("bp_ir_after_pop", 32'(int32_ir), 32'd1);
      drain("bp_drain");

      // Credit phase: fill, sustained accept+pop, then random backpressure against the model.
      pops0 = pops;
      accepts = 0;
      rop = 4'($urandom_range(0, 15)); ra = $urandom; rb = $urandom;
      for (int c = 0; c < 48; c++) begin
         int32_or = (c < 6) ? 1'b0 : (c < 14) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
         drive(rop, ra, rb);
         if (c >= 6 && c < 14) chk("full_ov_sustain", 32'(int32_ov), 32'd1);
         took = int32_ir;
         if (took) begin
            exp_q.push_back(ref_alu(rop, ra, rb));
            accepts++;
         end
         step();
         chk("full_busy", 32'(int32_busy), 32'd1);
         if (took) begin
            rop = 4'($urandom_range(0, 15)); ra = $urandom; rb = $urandom;
         end
      end
      int32_iv = 1'b0;
      int32_or = 1'b1;
      drain("full_drain");
      chk("full_pop_count", 32'(pops - pops0), 32'(accepts));

      // Illegal opcode between two ADDs.
      drive(4'd0, 32'd1, 32'd2);   exp_q.push_back({1'b0, 32'd3});  step();
      drive(4'd13, 32'd5, 32'd6);  exp_q.push_back({1'b1, 32'd0});  step();
      drive(4'd0, 32'd10, 32'd20); exp_q.push_back({1'b0, 32'd30}); step();
      int32_iv = 1'b0;
      step();
      chk("ill_err", 32'(int32_err), 32'd1);
      chk("ill_y", int32_y, 32'd0);
      drain("ill_drain");

      // Reset with ops in both stages and results buffered.
      int32_or = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(4'd0, 32'(i), 32'd1000);
         step();
      end
      int32_iv = 1'b0;
      chk("mid_busy", 32'(int32_busy), 32'd1);
      reset = 1'b1;
      step();
      chk("mid_rst_ov", 32'(int32_ov), 32'd0);
      chk("mid_rst_busy", 32'(int32_busy), 32'd0);
      chk("mid_rst_ir", 32'(int32_ir), 32'd0);
      chk("mid_rst_y", int32_y, 32'd0);
      int32_or = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("mid_ir_after_reset", 32'(int32_ir), 32'd1);
      pops0 = pops;
      drive(4'd1, 32'd9, 32'd4);
      exp_q.push_back({1'b0, 32'd5});
      step();
      int32_iv = 1'b0;
      repeat (8) step();
      chk("mid_single_pop", 32'(pops - pops0), 32'd1);
      chk("mid_final_ov", 32'(int32_ov), 32'd0);
      chk("mid_final_busy", 32'(int32_busy), 32'd0);
      chk("mid_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
